// File: rtl/obstacle_scheduler.sv
// -----------------------------------------------------------------------------
// obstacle_scheduler
// Frame-rate game sequencer for the Dino VGA display. On every frame boundary
// it scrolls the cactus left, despawns it near the dino's side of the screen,
// waits a pseudo-random gap before respawning, ramps the scroll speed, counts
// score and runs the IDLE/RUN/HIT/OVER game state machine.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous, active-high
//   frame_tick  in   end-of-frame level (may stay high several clocks)
//   start       in   debounced start/restart button level
//   collide     in   renderer flag: dino and cactus pixels overlap right now
//   cacti_x     out  cactus left edge
//   cacti_valid out  cactus present (renderer draws only when set)
//   speed       out  scroll speed, pixels/frame
//   score       out  frames survived, saturating
//   state       out  0 IDLE, 1 RUN, 2 HIT, 3 OVER
//   game_over   out  high exactly while in OVER
// -----------------------------------------------------------------------------
module obstacle_scheduler #(
    parameter int unsigned SPAWN_X        = 550,
    parameter int unsigned DESPAWN_X      = 80,
    parameter int unsigned START_SPEED    = 1,
    parameter int unsigned MAX_SPEED      = 8,
    parameter int unsigned SPEEDUP_FRAMES = 600,
    parameter int unsigned HIT_FRAMES     = 30,
    parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        collide,
    output logic [9:0]  cacti_x,
    output logic        cacti_valid,
    output logic [3:0]  speed,
    output logic [15:0] score,
    output logic [1:0]  state,
    output logic        game_over
);

    localparam int FRAME_W = $clog2(SPEEDUP_FRAMES);
    localparam int HIT_W   = $clog2(HIT_FRAMES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HIT  = 2'd2,
        S_OVER = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [9:0]           cacti_x_q, cacti_x_d;
    logic                 cacti_valid_q, cacti_valid_d;
    logic [3:0]           speed_q, speed_d;
    logic [15:0]          score_q, score_d;
    logic [7:0]           lfsr_q, lfsr_d;
    logic [6:0]           gap_q, gap_d;
    logic [FRAME_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [HIT_W-1:0]     hit_cnt_q, hit_cnt_d;
    logic                 hit_latch_q, hit_latch_d;
    logic                 frame_tick_q, frame_tick_d;
    logic                 start_q, start_d;

    logic                 fb;
    logic                 se;
    logic                 hit_now;
    logic [7:0]           lfsr_step;
    logic [10:0]          despawn_lim;

    // One-clock event pulses on the rising edge of the input levels.
    assign fb = frame_tick & ~frame_tick_q;
    assign se = start & ~start_q;

    // A collision only counts while a cactus is actually being drawn.
    assign hit_now = collide & cacti_valid_q & (state_q == S_RUN);

    // 8-bit Fibonacci LFSR, taps 8,6,5,4.
    assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // Widened so DESPAWN_X + speed cannot wrap.
    assign despawn_lim = 11'(DESPAWN_X) + 11'(speed_q);

    always_comb begin
        state_d       = state_q;
        cacti_x_d     = cacti_x_q;
        cacti_valid_d = cacti_valid_q;
        speed_d       = speed_q;
        score_d       = score_q;
        lfsr_d        = lfsr_q;
        gap_d         = gap_q;
        frame_cnt_d   = frame_cnt_q;
        hit_cnt_d     = hit_cnt_q;
        frame_tick_d  = frame_tick;
        start_d       = start;

        // Latch collisions between frame boundaries; a boundary consumes it.
        hit_latch_d = hit_latch_q | hit_now;
        if (fb || se) begin
            hit_latch_d = 1'b0;
        end

        case (state_q)
            S_IDLE, S_OVER: begin
                // Start wins over a coincident frame boundary.
                if (se) begin
                    state_d       = S_RUN;
                    cacti_x_d     = 10'(SPAWN_X);
                    cacti_valid_d = 1'b1;
                    speed_d       = 4'(START_SPEED);
                    score_d       = 16'd0;
                    frame_cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (fb) begin
                    // Include a collide arriving on the boundary clock itself.
                    if (hit_latch_q || hit_now) begin
                        state_d   = S_HIT;
                        hit_cnt_d = '0;
                    end else begin
                        if (score_q != 16'hFFFF) begin
                            score_d = score_q + 16'd1;
                        end
                        if (frame_cnt_q == FRAME_W'(SPEEDUP_FRAMES - 1)) begin
                            frame_cnt_d = '0;
                            if (speed_q < 4'(MAX_SPEED)) begin
                                speed_d = speed_q + 4'd1;
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_q + 1'b1;
                        end
                        lfsr_d = lfsr_step;
                        // Movement uses the speed from before this frame's ramp.
                        if (cacti_valid_q && ({1'b0, cacti_x_q} < despawn_lim)) begin
                            cacti_valid_d = 1'b0;
                            gap_d         = 7'd16 + 7'(lfsr_step[5:0]);
                        end else if (cacti_valid_q) begin
                            cacti_x_d = cacti_x_q - 10'(speed_q);
                        end else if (gap_q == 7'd0) begin
                            cacti_x_d     = 10'(SPAWN_X);
                            cacti_valid_d = 1'b1;
                        end else begin
                            gap_d = gap_q - 7'd1;
                        end
                    end
                end
            end
            S_HIT: begin
                if (fb) begin
                    if (hit_cnt_q == HIT_W'(HIT_FRAMES - 1)) begin
                        state_d = S_OVER;
                    end else begin
                        hit_cnt_d = hit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cacti_x_q     <= 10'(SPAWN_X);
            cacti_valid_q <= 1'b0;
            speed_q       <= 4'(START_SPEED);
            score_q       <= 16'd0;
            lfsr_q        <= LFSR_SEED;
            gap_q         <= 7'd0;
            frame_cnt_q   <= '0;
            hit_cnt_q     <= '0;
            hit_latch_q   <= 1'b0;
            frame_tick_q  <= 1'b0;
            start_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cacti_x_q     <= cacti_x_d;
            cacti_valid_q <= cacti_valid_d;
            speed_q       <= speed_d;
            score_q       <= score_d;
            lfsr_q        <= lfsr_d;
            gap_q         <= gap_d;
            frame_cnt_q   <= frame_cnt_d;
            hit_cnt_q     <= hit_cnt_d;
            hit_latch_q   <= hit_latch_d;
            frame_tick_q  <= frame_tick_d;
            start_q       <= start_d;
        end
    end

    assign cacti_x     = cacti_x_q;
    assign cacti_valid = cacti_valid_q;
    assign speed       = speed_q;
    assign score       = score_q;
    assign state       = state_q;
    assign game_over   = (state_q == S_OVER);

endmodule

// File: doc/obstacle_scheduler.md
Name: obstacle_scheduler

Overview:
Frame-rate game sequencer for the Dino VGA display. Once per video frame it moves the cactus sprite, schedules respawns with a pseudo-random gap, and ramps up scroll speed. It also tracks score and runs the IDLE/RUN/HIT/OVER game state machine. Outputs feed the renderer's cactus coordinates; the renderer's per-pixel dino/cactus overlap flag feeds back as collide.

Parameters:
SPAWN_X, 550, x coordinate loaded on spawn/start
DESPAWN_X, 80, cactus removed once its x would fall below this
START_SPEED, 1, pixels/frame after start
MAX_SPEED, 8, speed saturation value (≤15)
SPEEDUP_FRAMES, 600, RUN frames between speed increments
HIT_FRAMES, 30, frames spent frozen in HIT before OVER
LFSR_SEED, 8'hA5, LFSR reset value, must be nonzero

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-high
frame_tick  in  1  end-of-frame level from timing generator, may stay high several clk cycles
start  in  1  start/restart button, already debounced, level
collide  in  1  renderer flag: dino pixel and cactus pixel both set at the current pixel
cacti_x  out  10  cactus left edge
cacti_valid  out  1  cactus present; renderer draws only when 1
speed  out  4  current scroll speed, pixels/frame
score  out  16  frames survived, saturating
state  out  2  0 IDLE, 1 RUN, 2 HIT, 3 OVER
game_over  out  1  high exactly when state==OVER

Behaviour:
- Reset (async): state=IDLE, cacti_x=SPAWN_X, cacti_valid=0, speed=START_SPEED, score=0, game_over=0, lfsr=LFSR_SEED, gap=0, frame/hit counters=0, hit latch=0, edge registers=0.
- Edge detection: frame_tick and start are registered internally. A frame boundary (FB) is a one-clk pulse on the frame_tick 0→1 transition. A start event (SE) is a one-clk pulse on the start 0→1 transition. A level held high produces only one event.
- Hit latch: set in RUN on any clk where collide=1 and cacti_valid=1. Cleared on FB and on SE.
- IDLE: on SE, go to RUN on the next clk with cacti_x=SPAWN_X, cacti_valid=1, speed=START_SPEED, score=0, frame counter=0. FB is ignored in IDLE.
- RUN, on each FB (all outputs update on the clk after the FB pulse), in priority order:
  1. If the hit latch is set (including a collide on the same clk as FB), go to HIT, hit counter=0. Position, score and speed are frozen.
  2. Otherwise, score increments by 1, saturating at 16'hFFFF.
  3. The frame counter increments. At SPEEDUP_FRAMES-1 it wraps to 0 and speed increments, saturating at MAX_SPEED.
  4. The LFSR advances one step (8-bit Fibonacci, taps 8,6,5,4).
  5. If cacti_valid=1 and cacti_x < DESPAWN_X+speed: cacti_valid=0, gap=16+lfsr[5:0] (new LFSR value, giving 16..79 frames).
  6. Else, if cacti_valid=1: cacti_x = cacti_x - speed. Speed is the pre-update value.
  7. Else, if gap==0: cacti_x=SPAWN_X, cacti_valid=1.
  8. Else: gap decrements.
- SE in RUN is ignored.
- HIT: outputs frozen. Each FB increments the hit counter. On the FB where the counter equals HIT_FRAMES-1, go to OVER and set game_over=1. SE in HIT is ignored.
- OVER: outputs hold. On SE, perform the IDLE start action and go directly to RUN. game_over falls on the same clk.
- Simultaneous SE and FB in IDLE/OVER: the start action wins and the FB is discarded.
- Arithmetic:
  - cacti_x subtraction is 10-bit.
  - Underflow cannot occur because of the despawn check.
  - DESPAWN_X+speed is computed at 11 bits.
- Reset mid-frame or mid-HIT returns immediately to the reset values; no partial state survives.

Test Plan:
- Reset, pulse start, then 3 FBs → state=1, cacti_valid=1, cacti_x=547, score=3, speed=1.
- Hold frame_tick high for 10 clk cycles → exactly one FB; cacti_x drops by 1 only. Hold start high through RUN → no restart.
- Run 600 FBs with no collide → speed=2 after FB 600, frame counter wraps. Run 4200 more → speed saturates at 8.
- Run until cacti_x < 80+speed → cacti_valid=0 with gap in 16..79. Count FBs until cacti_valid=1 again at cacti_x=550; the count must equal gap+1, checked against a reference LFSR model seeded 8'hA5.
- Pulse collide for 1 clk mid-frame at cacti_x=300 → next FB: state=2, cacti_x stays 300, score frozen. After 30 further FBs: state=3, game_over=1. Pulse start → state=1, score=0, cacti_x=550, game_over=0.
- Assert reset during HIT → all outputs return to reset values asynchronously. Start and FB on the same clk in IDLE → RUN entered, score=0 (frame not counted).
